fft_frame_sequencer: RTL and testbench

//  Frame controller in front of and behind top_fft_module (512-pt, 16 lanes x 32 beats).

---
 rtl/fft_ctrl_pkg.sv | 24 ++
 rtl/fft_seq_timer.sv | 35 +++
 rtl/fft_frame_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_fft_frame_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fft_ctrl_pkg.sv
// Shared types and sizes for the FFT frame sequencer.
//  LANES/BEATS : frame geometry (512 points = 16 lanes x 32 beats)
//  IN_W/OUT_W  : sample widths into and out of top_fft_module
//  seq_state_t : sequencer FSM state encoding
//  in_beat_t / out_beat_t : one beat of lane data (lane k at [k])
package fft_ctrl_pkg;

  localparam int LANES = 16;
  localparam int BEATS = 32;
  localparam int IN_W  = 9;
  localparam int OUT_W = 13;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FEED     = 3'd1,
    WAIT_OUT = 3'd2,
    UNLOAD   = 3'd3,
    GAP      = 3'd4
  } seq_state_t;

  typedef logic [LANES-1:0][IN_W-1:0]  in_beat_t;
  typedef logic [LANES-1:0][OUT_W-1:0] out_beat_t;

endpackage

// File: rtl/fft_seq_timer.sv
// Loadable down-counter shared by the WAIT_OUT timeout and the GAP hold.
//  clk, rstn   : clock, asynchronous active-low reset
//  i_load      : load i_load_val (has priority over counting)
//  i_load_val  : value to load; o_done fires after i_load_val+1 run cycles
//  i_run       : count down while high; holds at zero
//  o_done      : combinational pulse while running with the count at zero
module fft_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_run,
  output logic         o_done
);

  logic [W-1:0] r_count;

  // Counter register: load, then count down to zero and stay there.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_run && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end else begin
      r_count <= r_count;
    end
  end

  assign o_done = i_run && (r_count == '0);

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame controller around top_fft_module: feeds one 32-beat frame as a
// contiguous fft_valid_in burst, collects the 32-beat result, marks the last
// beat and keeps status counters and sticky error flags.
//  clk, rstn                     : clock, asynchronous active-low reset
//  enable, clear_err             : frame start permission, sticky flag clear
//  s_valid/s_ready/s_re/s_im     : upstream beat handshake and data
//  fft_valid_in/fft_re/fft_im    : burst towards the FFT core
//  fft_valid_out/fft_dre/fft_dim : result burst from the FFT core
//  m_valid/m_re/m_im/m_last      : result beats downstream (no backpressure)
//  busy, frame_cnt, err_*        : status
module fft_frame_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int TMO_CYC = 255,
  parameter int GAP_CYC = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        clear_err,
  input  logic        s_valid,
  output logic        s_ready,
  input  in_beat_t    s_re,
  input  in_beat_t    s_im,
  output logic        fft_valid_in,
  output in_beat_t    fft_re,
  output in_beat_t    fft_im,
  input  logic        fft_valid_out,
  input  out_beat_t   fft_dre,
  input  out_beat_t   fft_dim,
  output logic        m_valid,
  output out_beat_t   m_re,
  output out_beat_t   m_im,
  output logic        m_last,
  output logic        busy,
  output logic [15:0] frame_cnt,
  output logic        err_underflow,
  output logic        err_timeout,
  output logic        err_short
);

  localparam logic [4:0] LAST_BEAT = 5'(BEATS - 1);
  localparam logic [7:0] TMO_LOAD  = 8'(TMO_CYC);
  localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYC - 1);

  seq_state_t r_state;
  seq_state_t w_next_state;
  logic [4:0] r_beat_cnt;
  logic [4:0] r_out_cnt;
  logic       w_tmr_load;
  logic [7:0] w_tmr_val;
  logic       w_tmr_run;
  logic       w_tmr_done;
  logic       w_issue;
  logic       w_capture;
  logic       w_unload_last;
  logic       w_set_uf;
  logic       w_set_to;
  logic       w_set_sh;

  // s_ready follows the state directly so it drops on the first WAIT_OUT cycle.
  assign s_ready = (r_state == IDLE) ? enable : (r_state == FEED);

  // A beat goes to the FFT on the accepting IDLE cycle and every FEED cycle,
  // which yields exactly BEATS back-to-back fft_valid_in cycles.
  assign w_issue       = ((r_state == IDLE) && enable && s_valid) || (r_state == FEED);
  assign w_capture     = fft_valid_out && ((r_state == WAIT_OUT) || (r_state == UNLOAD));
  assign w_unload_last = (r_state == UNLOAD) && fft_valid_out && (r_out_cnt == LAST_BEAT);
  assign w_tmr_run     = (r_state == WAIT_OUT) || (r_state == GAP);
  assign w_set_uf      = (r_state == FEED) && !s_valid;
  assign w_set_to      = (r_state == WAIT_OUT) && !fft_valid_out && w_tmr_done;
  assign w_set_sh      = (r_state == UNLOAD) && !fft_valid_out;

  // Next-state logic; the timer is loaded on every entry into WAIT_OUT or GAP.
  always_comb begin
    w_next_state = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = 8'd0;
    case (r_state)
      IDLE: begin
        if (enable && s_valid) begin
          w_next_state = FEED;
        end else begin
          w_next_state = IDLE;
        end
      end
      FEED: begin
        if (r_beat_cnt == LAST_BEAT) begin
          w_next_state = WAIT_OUT;
          w_tmr_load   = 1'b1;
          w_tmr_val    = TMO_LOAD;
        end else begin
          w_next_state = FEED;
        end
      end
      WAIT_OUT: begin
        // A result beat arriving on the timeout cycle still wins.
        if (fft_valid_out) begin
          w_next_state = UNLOAD;
        end else if (w_tmr_done) begin
          w_next_state = GAP;
          w_tmr_load   = 1'b1;
          w_tmr_val    = GAP_LOAD;
        end else begin
          w_next_state = WAIT_OUT;
        end
      end
      UNLOAD: begin
        if (!fft_valid_out || w_unload_last) begin
          w_next_state = GAP;
          w_tmr_load   = 1'b1;
          w_tmr_val    = GAP_LOAD;
        end else begin
          w_next_state = UNLOAD;
        end
      end
      GAP: begin
        if (w_tmr_done) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = GAP;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  fft_seq_timer #(.W(8)) u_timer (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_run      (w_tmr_run),
    .o_done     (w_tmr_done)
  );

  // State, beat counters and busy flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_beat_cnt <= 5'd0;
      r_out_cnt  <= 5'd0;
      busy       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      busy    <= (w_next_state != IDLE);
      case (r_state)
        IDLE:     r_beat_cnt <= w_issue ? 5'd1 : 5'd0;
        FEED:     r_beat_cnt <= (r_beat_cnt == LAST_BEAT) ? 5'd0 : r_beat_cnt + 5'd1;
        default:  r_beat_cnt <= 5'd0;
      endcase
      case (r_state)
        WAIT_OUT: r_out_cnt <= w_capture ? 5'd1 : 5'd0;
        UNLOAD:   r_out_cnt <= (w_capture && !w_unload_last) ? r_out_cnt + 5'd1 : 5'd0;
        default:  r_out_cnt <= 5'd0;
      endcase
    end
  end

  // Data registers: missing upstream beats and idle cycles drive zeros.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fft_valid_in <= 1'b0;
      fft_re       <= '0;
      fft_im       <= '0;
      m_valid      <= 1'b0;
      m_re         <= '0;
      m_im         <= '0;
      m_last       <= 1'b0;
    end else begin
      fft_valid_in <= w_issue;
      fft_re       <= (w_issue && s_valid) ? s_re : '0;
      fft_im       <= (w_issue && s_valid) ? s_im : '0;
      m_valid      <= w_capture;
      m_re         <= w_capture ? fft_dre : '0;
      m_im         <= w_capture ? fft_dim : '0;
      m_last       <= w_unload_last;
    end
  end

  // Frame counter and sticky flags; a set in the clearing cycle wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      frame_cnt     <= 16'd0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
      err_short     <= 1'b0;
    end else begin
      frame_cnt     <= w_unload_last ? frame_cnt + 16'd1 : frame_cnt;
      err_underflow <= w_set_uf || (err_underflow && !clear_err);
      err_timeout   <= w_set_to || (err_timeout && !clear_err);
      err_short     <= w_set_sh || (err_short && !clear_err);
    end
  end

endmodule

// File: tb/tb_fft_frame_sequencer.sv
module tb_fft_frame_sequencer;
  import fft_ctrl_pkg::*;

  localparam int TMO     = 255;
  localparam int WAIT0   = 32;              // first WAIT_OUT cycle of a frame
  localparam int TO_RISE = WAIT0 + TMO + 1; // first cycle err_timeout reads 1

  logic        clk = 1'b0;
  logic        rstn, enable, clear_err, s_valid, fft_valid_out;
  logic        s_ready, fft_valid_in, m_valid, m_last, busy;
  logic        err_underflow, err_timeout, err_short;
  logic [15:0] frame_cnt;
  in_beat_t    s_re, s_im, fft_re, fft_im;
  out_beat_t   fft_dre, fft_dim, m_re, m_im;

  int n_pass  = 0;
  int n_total = 0;
  int fc_exp  = 0;

  fft_frame_sequencer dut (
    .clk(clk), .rstn(rstn), .enable(enable), .clear_err(clear_err),
    .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
    .fft_valid_in(fft_valid_in), .fft_re(fft_re), .fft_im(fft_im),
    .fft_valid_out(fft_valid_out), .fft_dre(fft_dre), .fft_dim(fft_dim),
    .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_last(m_last),
    .busy(busy), .frame_cnt(frame_cnt), .err_underflow(err_underflow),
    .err_timeout(err_timeout), .err_short(err_short)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string name;
    int    gap;      // FEED cycle with s_valid low (-1: none)
    int    clr;      // cycle with clear_err high (-1: none)
    int    rsp;      // first fft_valid_out cycle of the result burst
    int    len;      // result burst length (0: no burst)
    int    spur;     // stray fft_valid_out cycle (-1: none)
    int    exp_end;  // first cycle back in IDLE
    bit    exp_uf, exp_to, exp_sh, exp_inc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int t, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0d got %h want %h", name, t, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic in_beat_t mk_in(input int b, input bit im);
    in_beat_t v;
    for (int k = 0; k < LANES; k++) begin
      v[k] = im ? 9'(511 - (b * 16 + k)) : 9'(b * 16 + k);
    end
    return v;
  endfunction

  function automatic out_beat_t mk_out(input int j, input bit im);
    out_beat_t v;
    for (int k = 0; k < LANES; k++) begin
      v[k] = im ? 13'(8191 - (j * 37 + k * 5 + 100)) : 13'(j * 37 + k * 5 + 100);
    end
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_s_ready"}, 0, s_ready, 0);
    chk({tag, "_fvi"},     0, fft_valid_in, 0);
    chk({tag, "_fft_re"},  0, fft_re, 0);
    chk({tag, "_fft_im"},  0, fft_im, 0);
    chk({tag, "_m_valid"}, 0, m_valid, 0);
    chk({tag, "_m_re"},    0, m_re, 0);
    chk({tag, "_m_im"},    0, m_im, 0);
    chk({tag, "_m_last"},  0, m_last, 0);
    chk({tag, "_busy"},    0, busy, 0);
    chk({tag, "_fcnt"},    0, frame_cnt, 0);
    chk({tag, "_flags"},   0, {err_underflow, err_timeout, err_short}, 0);
  endtask

  // Runs one frame cycle by cycle from IDLE; cycle 0 presents the first beat.
  task automatic run_frame(input vec_t v, input int abort_t);
    bit fvo, e_fvi, e_mv;
    for (int t = 0; t <= v.exp_end; t++) begin
      e_fvi = (t >= 1) && (t <= 32);
      e_mv  = (v.len > 0) && (t >= v.rsp + 1) && (t <= v.rsp + v.len);
      chk({v.name, "_fvi"},  t, fft_valid_in, e_fvi);
      chk({v.name, "_fre"},  t, fft_re, (e_fvi && (t - 1) != v.gap) ? mk_in(t - 1, 1'b0) : '0);
      chk({v.name, "_fim"},  t, fft_im, (e_fvi && (t - 1) != v.gap) ? mk_in(t - 1, 1'b1) : '0);
      chk({v.name, "_mv"},   t, m_valid, e_mv);
      chk({v.name, "_mre"},  t, m_re, e_mv ? mk_out(t - v.rsp - 1, 1'b0) : '0);
      chk({v.name, "_mim"},  t, m_im, e_mv ? mk_out(t - v.rsp - 1, 1'b1) : '0);
      chk({v.name, "_mlast"}, t, m_last, (v.len == 32) && (t == v.rsp + 32));
      chk({v.name, "_busy"}, t, busy, (t >= 1) && (t < v.exp_end));
      chk({v.name, "_rdy"},  t, s_ready, (t <= 31) || (t >= v.exp_end));
      chk({v.name, "_uf"},   t, err_underflow, (v.gap >= 0) && (t >= v.gap + 1));
      chk({v.name, "_to"},   t, err_timeout, v.exp_to && (t >= TO_RISE));
      chk({v.name, "_sh"},   t, err_short, v.exp_sh && (t >= v.rsp + v.len + 1));
      chk({v.name, "_fcnt"}, t, frame_cnt, 16'(fc_exp + ((v.exp_inc && t >= v.rsp + 32) ? 1 : 0)));
      if (t == v.exp_end) break;
      fvo           = ((v.len > 0) && (t >= v.rsp) && (t < v.rsp + v.len)) || (t == v.spur);
      enable        = 1'b1;
      s_valid       = (t < 32) && (t != v.gap);
      s_re          = mk_in(t, 1'b0);
      s_im          = mk_in(t, 1'b1);
      clear_err     = (t == v.clr);
      fft_valid_out = fvo;
      fft_dre       = fvo ? mk_out(t - v.rsp, 1'b0) : '0;
      fft_dim       = fvo ? mk_out(t - v.rsp, 1'b1) : '0;
      if (t == abort_t) begin
        rstn   = 1'b0;
        enable = 1'b0;
        #1;
        chk_all_zero("abort");
        return;
      end
      step();
    end
    chk({v.name, "_end_flags"}, v.exp_end, {err_underflow, err_timeout, err_short},
        {v.exp_uf, v.exp_to, v.exp_sh});
    fc_exp = fc_exp + (v.exp_inc ? 1 : 0);
    // One idle cycle with clear_err to drop the sticky flags.
    s_valid       = 1'b0;
    fft_valid_out = 1'b0;
    clear_err     = 1'b1;
    step();
    clear_err = 1'b0;
    chk({v.name, "_cleared"}, 0, {err_underflow, err_timeout, err_short}, 3'b000);
  endtask

  initial begin
    //             name          gap clr  rsp len spur end  uf to sh inc
    vecs[0] = '{"clean",        -1, -1,  41, 32, -1,  75, 0, 0, 0, 1};
    vecs[1] = '{"underflow",    10, 10,  41, 32, -1,  75, 1, 0, 0, 1};
    vecs[2] = '{"delay40",      -1, -1,  72, 32, -1, 106, 0, 0, 0, 1};
    vecs[3] = '{"timeout",      -1, -1,   0,  0, 10, 290, 0, 1, 0, 0};
    vecs[4] = '{"short20",      -1, -1,  41, 20, -1,  64, 0, 0, 1, 0};
    vecs[5] = '{"recover",      -1, -1,  41, 32, -1,  75, 0, 0, 0, 1};
    vecs[6] = '{"late_edge",    -1, -1, 287, 32, -1, 321, 0, 0, 0, 1};

    rstn = 1'b0; enable = 1'b0; clear_err = 1'b0; s_valid = 1'b0;
    fft_valid_out = 1'b0; s_re = '0; s_im = '0; fft_dre = '0; fft_dim = '0;
    repeat (3) step();
    chk_all_zero("reset");
    rstn = 1'b1;
    step();
    // enable low: an offered beat must not start a frame.
    s_valid = 1'b1;
    s_re    = mk_in(0, 1'b0);
    step();
    chk("noenable_busy", 0, busy, 1'b0);
    chk("noenable_fvi",  0, fft_valid_in, 1'b0);
    s_valid = 1'b0;
    enable  = 1'b1;
    #1;
    chk("enable_rdy", 0, s_ready, 1'b1);
    step();

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i], -1);
    end

    // Reset while UNLOAD is on beat 15 of the result burst.
    run_frame(vecs[0], 41 + 15);
    step();
    chk_all_zero("inreset");
    rstn   = 1'b1;
    enable = 1'b1;
    fft_valid_out = 1'b0;
    s_valid = 1'b0;
    step();
    chk("post_rst_busy", 0, busy, 1'b0);
    chk("post_rst_rdy",  0, s_ready, 1'b1);
    chk("post_rst_fcnt", 0, frame_cnt, 16'd0);
    fc_exp = 0;
    run_frame(vecs[0], -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
